id_ex_ctrl_stage: RTL and testbench
===================================

Name: id_ex_ctrl_stage

Overview:
Decode-to-execute control stage for the five-stage MIPS pipeline. It decodes the ID-stage instruction into datapath control, including the 3-bit alucontrol consumed by the EX-stage ALU. Results are captured in the ID/EX pipeline register, with stall (hold) and flush (bubble) support. It also flags unsupported instructions and keeps a saturating count of them for debug.

Parameters:
- INSTR_W, 32, instruction width; only 32 is supported.
- ILLCNT_W, 8, width of the illegal-instruction counter.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- instr_d  input  INSTR_W  ID-stage instruction.
- valid_d  input  1  instr_d holds a real instruction.
- stall_e  input  1  hold the ID/EX register contents.
- flush_e  input  1  load a bubble into ID/EX.
- regwrite_e  output  1  register file write enable.
- memtoreg_e  output  1  writeback selects memory data.
- memwrite_e  output  1  data memory write enable.
- alusrc_e  output  1  ALU srcb selects the immediate.
- regdst_e  output  1  destination register is rd (1) or rt (0).
- zeroext_e  output  1  immediate is zero-extended (andi/ori).
- branch_e  output  1  beq.
- jump_e  output  1  j.
- alucontrol_e  output  3  ALU operation code.
- rs_e, rt_e, rd_e  output  5 each  register fields, for hazard and forwarding logic.
- valid_e  output  1  EX slot holds a real instruction.
- illegal_e  output  1  EX slot came from an unsupported instruction.
- illcnt  output  ILLCNT_W  saturating count of illegal instructions accepted.

Behaviour:
- alucontrol encoding, shared with the ALU:
  - 000 AND, 001 OR, 010 ADD, 011 zero, 100 A&~B, 101 A|~B, 110 SUB, 111 SLT.
- Decode is combinational from instr_d. Outputs are registered, so latency is 1 cycle.
- Opcode and funct mapping (instr[31:26], instr[5:0]):
  - R-type 000000: regwrite=1, regdst=1. funct 100000 gives 010, 100010 gives 110, 100100 gives 000, 100101 gives 001, 101010 gives 111.
  - lw 100011: regwrite=1, alusrc=1, memtoreg=1, alucontrol=010.
  - sw 101011: memwrite=1, alusrc=1, alucontrol=010.
  - beq 000100: branch=1, alucontrol=110.
  - addi 001000: regwrite=1, alusrc=1, alucontrol=010.
  - andi 001100: as addi, with zeroext=1 and alucontrol=000.
  - ori 001101: as addi, with zeroext=1 and alucontrol=001.
  - slti 001010: regwrite=1, alusrc=1, alucontrol=111.
  - j 000010: jump=1, alucontrol=010.
- instr_d == 0 (nop) is valid: all enables 0, alucontrol=011, not illegal.
- Any other opcode, or an R-type funct outside the list, is illegal:
  - all enables 0, alucontrol=011, valid_e=0, illegal_e=1.
  - illcnt increments by 1 and saturates at all-ones; it never wraps.
- Bubble value: all enable outputs 0, alucontrol=011, valid_e=0, illegal_e=0, rs/rt/rd=0.
- Update priority each clock, highest first:
  - reset: ID/EX register holds the bubble and illcnt=0.
  - else flush_e: load the bubble. Flush wins over a simultaneous stall.
  - else stall_e: hold every output and illcnt. A held illegal instruction is not counted again.
  - else valid_d=0: load the bubble.
  - else: load the decoded instr_d and its rs/rt/rd fields (instr[25:21], [20:16], [15:11]).
- illcnt increments only on a cycle that actually loads an illegal instruction.
- Reset mid-stall or mid-flush leaves the bubble in place and clears the counter.
- No X may be driven on any output after reset, including for unsupported encodings.

Decomposition:
- Package mips_pkg holds the alucontrol_t enum (the 8 codes above), opcode and funct localparams, the ctrl_t packed struct of enables, and the BUBBLE constant.
- One natural sub-module, main_alu_decoder: pure combinational, instr maps to ctrl_t plus an illegal flag.
- The parent holds the ID/EX register, the priority logic and the counter.

Test Plan:
- Reset, then valid_d=1 with add $3,$1,$2 (0x00221820): next cycle regwrite_e=1, regdst_e=1, alucontrol_e=010, rs_e=1, rt_e=2, rd_e=3, valid_e=1.
- Sequence lw, sw, beq, ori, slti, j on consecutive cycles: each appears 1 cycle later with alucontrol 010, 010, 110, 001, 111, 010; memtoreg_e=1 only for lw; zeroext_e=1 only for ori.
- Load sub, then assert stall_e for 3 cycles with a different instr_d: outputs stay as sub (110) for all 3 cycles, then update the cycle after stall_e drops.
- stall_e=1 and flush_e=1 together: the next cycle shows the bubble (valid_e=0, alucontrol_e=011, all enables 0).
- 300 back-to-back illegal opcodes (0xFC000000) with ILLCNT_W=8: illegal_e=1 each cycle and illcnt stops at 255. One stalled illegal held 5 cycles adds exactly 1 to the count.
- reset asserted mid-stream after several instructions: the next cycle shows the bubble and illcnt=0. instr_d=0 then gives valid_e=1, illegal_e=0, alucontrol_e=011.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS decode/execute control path: ALU operation codes,
// opcode/funct values, the control bundle carried into EX and its bubble value.
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_ZERO = 3'b011,
    ALU_ANDN = 3'b100,
    ALU_ORN  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alucontrol_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic        alusrc;
    logic        regdst;
    logic        zeroext;
    logic        branch;
    logic        jump;
    alucontrol_t alucontrol;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '{
    regwrite: 1'b0, memtoreg: 1'b0, memwrite: 1'b0, alusrc: 1'b0,
    regdst: 1'b0, zeroext: 1'b0, branch: 1'b0, jump: 1'b0,
    alucontrol: ALU_ZERO
  };

  typedef struct packed {
    ctrl_t      ctrl;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       valid;
    logic       illegal;
  } idex_t;

endpackage

// File: rtl/main_alu_decoder.sv
// Combinational main + ALU decoder: maps one instruction word to the EX control
// bundle, flagging encodings this pipeline does not implement.
module main_alu_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        illegal_o
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr_i[31:26];
  assign funct  = instr_i[5:0];

  always_comb begin
    ctrl_o    = BUBBLE;
    illegal_o = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        // The all-zero word is the canonical nop and must not write $0 or trap.
        if (instr_i != 32'd0) begin
          ctrl_o.regwrite = 1'b1;
          ctrl_o.regdst   = 1'b1;
          case (funct)
            FN_ADD:  ctrl_o.alucontrol = ALU_ADD;
            FN_SUB:  ctrl_o.alucontrol = ALU_SUB;
            FN_AND:  ctrl_o.alucontrol = ALU_AND;
            FN_OR:   ctrl_o.alucontrol = ALU_OR;
            FN_SLT:  ctrl_o.alucontrol = ALU_SLT;
            default: begin
              ctrl_o    = BUBBLE;
              illegal_o = 1'b1;
            end
          endcase
        end
      end
      OP_LW: begin
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.alusrc     = 1'b1;
        ctrl_o.memtoreg   = 1'b1;
        ctrl_o.alucontrol = ALU_ADD;
      end
      OP_SW: begin
        ctrl_o.memwrite   = 1'b1;
        ctrl_o.alusrc     = 1'b1;
        ctrl_o.alucontrol = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_o.branch     = 1'b1;
        ctrl_o.alucontrol = ALU_SUB;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.zeroext  = (opcode == OP_ANDI) || (opcode == OP_ORI);
        case (opcode)
          OP_ANDI: ctrl_o.alucontrol = ALU_AND;
          OP_ORI:  ctrl_o.alucontrol = ALU_OR;
          OP_SLTI: ctrl_o.alucontrol = ALU_SLT;
          default: ctrl_o.alucontrol = ALU_ADD;
        endcase
      end
      OP_J: begin
        ctrl_o.jump       = 1'b1;
        ctrl_o.alucontrol = ALU_ADD;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control stage: decodes the ID instruction and registers the control into EX,
// with flush/stall handling and a saturating count of unsupported instructions.
module id_ex_ctrl_stage
  import mips_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int ILLCNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INSTR_W-1:0]  instr_d,
  input  logic                valid_d,
  input  logic                stall_e,
  input  logic                flush_e,
  output logic                regwrite_e,
  output logic                memtoreg_e,
  output logic                memwrite_e,
  output logic                alusrc_e,
  output logic                regdst_e,
  output logic                zeroext_e,
  output logic                branch_e,
  output logic                jump_e,
  output logic [2:0]          alucontrol_e,
  output logic [4:0]          rs_e,
  output logic [4:0]          rt_e,
  output logic [4:0]          rd_e,
  output logic                valid_e,
  output logic                illegal_e,
  output logic [ILLCNT_W-1:0] illcnt
);

  localparam idex_t IDEX_BUBBLE = '{
    ctrl: BUBBLE, rs: 5'd0, rt: 5'd0, rd: 5'd0, valid: 1'b0, illegal: 1'b0
  };

  ctrl_t               dec_ctrl;
  logic                dec_illegal;
  idex_t               idex_q, idex_d;
  logic [ILLCNT_W-1:0] illcnt_q, illcnt_d;

  main_alu_decoder u_dec (
    .instr_i   (instr_d),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    idex_d   = idex_q;
    illcnt_d = illcnt_q;
    if (flush_e) begin
      idex_d = IDEX_BUBBLE;
    end else if (stall_e) begin
      idex_d = idex_q;
    end else if (!valid_d) begin
      idex_d = IDEX_BUBBLE;
    end else begin
      idex_d.ctrl    = dec_ctrl;
      idex_d.rs      = instr_d[25:21];
      idex_d.rt      = instr_d[20:16];
      idex_d.rd      = instr_d[15:11];
      idex_d.valid   = !dec_illegal;
      idex_d.illegal = dec_illegal;
      // Count only fresh loads, so a held illegal is never counted twice.
      if (dec_illegal && (illcnt_q != {ILLCNT_W{1'b1}})) begin
        illcnt_d = illcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q   <= IDEX_BUBBLE;
      illcnt_q <= '0;
    end else begin
      idex_q   <= idex_d;
      illcnt_q <= illcnt_d;
    end
  end

  assign regwrite_e   = idex_q.ctrl.regwrite;
  assign memtoreg_e   = idex_q.ctrl.memtoreg;
  assign memwrite_e   = idex_q.ctrl.memwrite;
  assign alusrc_e     = idex_q.ctrl.alusrc;
  assign regdst_e     = idex_q.ctrl.regdst;
  assign zeroext_e    = idex_q.ctrl.zeroext;
  assign branch_e     = idex_q.ctrl.branch;
  assign jump_e       = idex_q.ctrl.jump;
  assign alucontrol_e = idex_q.ctrl.alucontrol;
  assign rs_e         = idex_q.rs;
  assign rt_e         = idex_q.rt;
  assign rd_e         = idex_q.rd;
  assign valid_e      = idex_q.valid;
  assign illegal_e    = idex_q.illegal;
  assign illcnt       = illcnt_q;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Bench for id_ex_ctrl_stage: table-driven reference model compared every cycle,
// plus directed literal expectations on the key scenarios.
module tb_id_ex_ctrl_stage;

  logic        clk;
  logic        reset;
  logic [31:0] instr_d;
  logic        valid_d, stall_e, flush_e;
  logic        regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e, zeroext_e;
  logic        branch_e, jump_e, valid_e, illegal_e;
  logic [2:0]  alucontrol_e;
  logic [4:0]  rs_e, rt_e, rd_e;
  logic [7:0]  illcnt;

  int checks = 0;
  int errors = 0;

  id_ex_ctrl_stage #(.INSTR_W(32), .ILLCNT_W(8)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e),
    .alusrc_e(alusrc_e), .regdst_e(regdst_e), .zeroext_e(zeroext_e),
    .branch_e(branch_e), .jump_e(jump_e), .alucontrol_e(alucontrol_e),
    .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .valid_e(valid_e),
    .illegal_e(illegal_e), .illcnt(illcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference table: {illegal, regwrite,memtoreg,memwrite,alusrc,regdst,zeroext,branch,jump, alu[2:0]}
  function automatic logic [11:0] ref_dec(input logic [31:0] i);
    if (i == 32'd0) return {1'b0, 8'b0000_0000, 3'b011};
    case (i[31:26])
      6'h00: case (i[5:0])
               6'h20:   return {1'b0, 8'b1000_1000, 3'b010};
               6'h22:   return {1'b0, 8'b1000_1000, 3'b110};
               6'h24:   return {1'b0, 8'b1000_1000, 3'b000};
               6'h25:   return {1'b0, 8'b1000_1000, 3'b001};
               6'h2a:   return {1'b0, 8'b1000_1000, 3'b111};
               default: return {1'b1, 8'b0000_0000, 3'b011};
             endcase
      6'h23:   return {1'b0, 8'b1101_0000, 3'b010};
      6'h2b:   return {1'b0, 8'b0011_0000, 3'b010};
      6'h04:   return {1'b0, 8'b0000_0010, 3'b110};
      6'h08:   return {1'b0, 8'b1001_0000, 3'b010};
      6'h0c:   return {1'b0, 8'b1001_0100, 3'b000};
      6'h0d:   return {1'b0, 8'b1001_0100, 3'b001};
      6'h0a:   return {1'b0, 8'b1001_0000, 3'b111};
      6'h02:   return {1'b0, 8'b0000_0001, 3'b010};
      default: return {1'b0 | 1'b1, 8'b0000_0000, 3'b011};
    endcase
  endfunction

  // Model state: what the EX slot should hold
  logic [10:0] m_ctrl;
  logic [14:0] m_regs;
  logic        m_valid, m_ill;
  int          m_cnt;
  bit          m_ok = 1'b0;

  always @(posedge clk) begin
    logic [11:0] d;
    if (reset) begin
      m_ctrl = {8'b0, 3'b011}; m_regs = '0; m_valid = 0; m_ill = 0; m_cnt = 0; m_ok = 1;
    end else if (flush_e) begin
      m_ctrl = {8'b0, 3'b011}; m_regs = '0; m_valid = 0; m_ill = 0;
    end else if (stall_e) begin
      // hold
    end else if (!valid_d) begin
      m_ctrl = {8'b0, 3'b011}; m_regs = '0; m_valid = 0; m_ill = 0;
    end else begin
      d = ref_dec(instr_d);
      m_ctrl  = d[10:0];
      m_ill   = d[11];
      m_valid = !d[11];
      m_regs  = {instr_d[25:21], instr_d[20:16], instr_d[15:11]};
      if (d[11] && m_cnt < 255) m_cnt = m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("cycle",
          {28'd0, regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e, zeroext_e,
           branch_e, jump_e, alucontrol_e, rs_e, rt_e, rd_e, valid_e, illegal_e, illcnt},
          {28'd0, m_ctrl, m_regs, m_valid, m_ill, m_cnt[7:0]});
    end
  end

  task automatic step(input logic [31:0] ins, input logic v, input logic st,
                      input logic fl, input logic rs);
    instr_d = ins; valid_d = v; stall_e = st; flush_e = fl; reset = rs;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] seq_instr [6];
  logic [2:0]  seq_alu   [6];

  initial begin
    seq_instr = '{32'h8C220004, 32'hAC220004, 32'h10220003,
                  32'h34220005, 32'h28220005, 32'h08000010};
    seq_alu   = '{3'b010, 3'b010, 3'b110, 3'b001, 3'b111, 3'b010};

    instr_d = '0; valid_d = 0; stall_e = 0; flush_e = 0; reset = 1;
    step(32'h0, 0, 0, 0, 1);
    step(32'h0, 0, 0, 0, 1);
    chk("reset_bubble", {valid_e, illegal_e, alucontrol_e, regwrite_e, illcnt},
        {1'b0, 1'b0, 3'b011, 1'b0, 8'd0});

    // add $3,$1,$2
    step(32'h00221820, 1, 0, 0, 0);
    chk("add", {regwrite_e, regdst_e, alucontrol_e, rs_e, rt_e, rd_e, valid_e},
        {1'b1, 1'b1, 3'b010, 5'd1, 5'd2, 5'd3, 1'b1});

    for (int k = 0; k < 6; k++) begin
      step(seq_instr[k], 1, 0, 0, 0);
      chk("seq_alu", {29'd0, alucontrol_e}, {29'd0, seq_alu[k]});
      chk("seq_memtoreg_zeroext", {memtoreg_e, zeroext_e}, {k == 0, k == 3});
    end

    // sub $5,$3,$4 then stall with an and in ID
    step(32'h00642822, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(32'h00642824, 1, 1, 0, 0);
      chk("stall_hold", {29'd0, alucontrol_e}, {29'd0, 3'b110});
    end
    step(32'h00642824, 1, 0, 0, 0);
    chk("after_stall", {29'd0, alucontrol_e}, {29'd0, 3'b000});

    step(32'h00642825, 1, 1, 1, 0);
    chk("flush_over_stall", {valid_e, alucontrol_e, regwrite_e, regdst_e},
        {1'b0, 3'b011, 1'b0, 1'b0});

    step(32'h0064282A, 1, 0, 0, 0);
    step(32'h0064282A, 0, 0, 0, 0);
    chk("valid_low_bubble", {valid_e, rs_e, rt_e, rd_e}, 16'd0);
    step(32'h00642825, 1, 0, 0, 0);
    step(32'h20220007, 1, 0, 0, 0);
    step(32'h30220007, 1, 0, 0, 0);
    chk("andi", {zeroext_e, alusrc_e, alucontrol_e}, {1'b1, 1'b1, 3'b000});
    step(32'h00642821, 1, 0, 0, 0);
    chk("bad_funct", {valid_e, illegal_e, regwrite_e, alucontrol_e, illcnt},
        {1'b0, 1'b1, 1'b0, 3'b011, 8'd1});

    // Held illegal counted once
    step(32'h0, 0, 0, 0, 1);
    step(32'hFC000000, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(32'hFC000000, 1, 1, 0, 0);
    chk("stalled_illegal_once", {illegal_e, illcnt}, {1'b1, 8'd1});

    for (int k = 0; k < 300; k++) step(32'hFC000000, 1, 0, 0, 0);
    chk("illcnt_saturate", {illegal_e, valid_e, illcnt}, {1'b1, 1'b0, 8'd255});

    step(32'h00221820, 1, 0, 0, 0);
    step(32'h8C220004, 1, 1, 0, 0);
    step(32'h8C220004, 1, 1, 1, 1);
    chk("reset_mid_stream", {valid_e, regwrite_e, alucontrol_e, illcnt},
        {1'b0, 1'b0, 3'b011, 8'd0});

    step(32'h0, 1, 0, 0, 0);
    chk("nop", {valid_e, illegal_e, regwrite_e, alucontrol_e}, {1'b1, 1'b0, 1'b0, 3'b011});

    step(32'h0, 0, 0, 0, 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
